// File: rtl/sram_pkg.sv
// Shared types and defaults for the SRAM backing-store controller.
package sram_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int          HW_PER_LINE   = 4;
  localparam int          HW_PER_WORD   = 2;
  localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
  localparam int          DEF_PHASE_CYC = 2;
endpackage

// File: rtl/sram_phase_counter.sv
// Nested phase / halfword counters pacing one SRAM transfer of limit halfwords.
module sram_phase_counter
  import sram_pkg::*;
#(
  parameter int PHASE_CYC = DEF_PHASE_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] limit,
  output logic [1:0] hw_idx,
  output logic       phase_last,
  output logic       xfer_last
);
  localparam int            PW    = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PHASE_CYC - 1);

  logic [PW-1:0] phase_q;

  assign phase_last = (phase_q == PLAST);
  assign xfer_last  = phase_last && ({1'b0, hw_idx} == (limit - 3'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      hw_idx  <= '0;
    end else if (en) begin
      if (phase_last) begin
        phase_q <= '0;
        hw_idx  <= xfer_last ? 2'd0 : hw_idx + 2'd1;
      end else begin
        phase_q <= phase_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sram_controller.sv
// Line-read / word-write controller for a 16-bit asynchronous SRAM behind the data cache.
// Optional build macro SRAM_STATS_EN adds per-mode transfer counters.
module sram_controller
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          PHASE_CYC = DEF_PHASE_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [63:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
`ifdef SRAM_STATS_EN
  ,
  output logic [31:0] stat_rd_cnt,
  output logic [31:0] stat_wr_cnt
`endif
);
  state_t      state, state_nx;
  logic        wr_mode;
  logic [2:0]  limit;
  logic [1:0]  hw_idx;
  logic        phase_last, xfer_last;
  logic        in_acc, wr_acc;
  logic [31:0] offs;
  logic [17:0] rd_base, wr_base;
  logic [15:0] dq_out;

  assign offs    = address - BASE_ADDR;
  assign rd_base = {offs[18:3], 2'b00};
  assign wr_base = {offs[18:2], 1'b0};
  assign in_acc  = (state == ACCESS);
  assign wr_acc  = in_acc & wr_mode;
  assign limit   = wr_mode ? 3'(HW_PER_WORD) : 3'(HW_PER_LINE);

  sram_phase_counter #(.PHASE_CYC(PHASE_CYC)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (in_acc),
    .limit      (limit),
    .hw_idx     (hw_idx),
    .phase_last (phase_last),
    .xfer_last  (xfer_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_mode <= 1'b0;
    end else begin
      state <= state_nx;
      // wr_en wins over a simultaneous rd_en
      if (state == IDLE && (wr_en || rd_en))
        wr_mode <= wr_en;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (wr_en || rd_en) state_nx = ACCESS;
      ACCESS:  if (xfer_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign ready = (state == DONE) | ((state == IDLE) & ~rd_en & ~wr_en);

  // Strobe released on the final cycle of each write phase so data is held past WE_N rising.
  assign SRAM_ADDR = in_acc ? ((wr_mode ? wr_base : rd_base) + {16'd0, hw_idx}) : 18'd0;
  assign SRAM_WE_N = ~(wr_acc & ~phase_last);
  assign SRAM_OE_N = wr_acc;
  assign dq_out    = hw_idx[0] ? write_data[31:16] : write_data[15:0];
  assign SRAM_DQ   = wr_acc ? dq_out : 16'hzzzz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      read_data <= '0;
    else if (in_acc && !wr_mode && phase_last)
      read_data[{hw_idx, 4'b0000} +: 16] <= SRAM_DQ;
  end

`ifdef SRAM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else if (in_acc && xfer_last) begin
      if (wr_mode) stat_wr_cnt <= stat_wr_cnt + 32'd1;
      else         stat_rd_cnt <= stat_rd_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: transaction-level schedule model checked every cycle plus directed literals.
module tb_sram_controller;
  localparam int P = 2;

  logic        clk = 1'b0;
  logic        rst, rd_en, wr_en;
  logic [31:0] address, write_data;
  logic [63:0] read_data;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;
`ifdef SRAM_STATS_EN
  logic [31:0] stat_rd_cnt, stat_wr_cnt;
`endif

  sram_controller #(.BASE_ADDR(32'd1024), .PHASE_CYC(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (SRAM_DQ),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_WE_N  (SRAM_WE_N),
    .SRAM_OE_N  (SRAM_OE_N),
    .SRAM_CE_N  (SRAM_CE_N),
    .SRAM_UB_N  (SRAM_UB_N),
    .SRAM_LB_N  (SRAM_LB_N)
`ifdef SRAM_STATS_EN
    ,
    .stat_rd_cnt(stat_rd_cnt),
    .stat_wr_cnt(stat_wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  // SRAM device: read-only contents set by the stimulus, drives only while output-enabled
  logic [15:0] mem [0:63];
  bit          mdl_on;
  assign SRAM_DQ = (mdl_on && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[5:0]] : 16'hzzzz;

  int cmp_n = 0;
  int err_n = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          acc;
    bit          rdy;
    logic [17:0] addr;
    bit          we_n;
    bit          oe_n;
    bit          drv;
    logic [15:0] dq;
    bit          last_rd;
    bit          last_wr;
    logic [17:0] base;
  } rec_t;

  rec_t        q[$];
  logic [63:0] exp_rd;
  int          exp_rdn, exp_wrn;

  function automatic logic [17:0] hw_base(input logic [31:0] a, input bit word);
    logic [31:0] offs;
    offs = a - 32'd1024;
    return word ? 18'((offs / 4) * 2) : 18'((offs / 8) * 4);
  endfunction

  // Expected per-cycle outputs of one whole transfer, from the cycle after the request is seen
  task automatic push_sched(input bit w, input logic [31:0] a, input logic [31:0] d);
    rec_t        r;
    int          n;
    logic [17:0] b;
    n = w ? 2 : 4;
    b = hw_base(a, w);
    for (int i = 0; i < n; i++) begin
      for (int p = 0; p < P; p++) begin
        r      = '{default: 0};
        r.acc  = 1;
        r.addr = b + 18'(i);
        r.we_n = w ? (p == P - 1) : 1'b1;
        r.oe_n = w;
        r.drv  = w;
        r.dq   = w ? ((i == 0) ? d[15:0] : d[31:16]) : 16'h0;
        q.push_back(r);
      end
    end
    r         = '{default: 0};
    r.rdy     = 1;
    r.we_n    = 1;
    r.last_rd = !w;
    r.last_wr = w;
    r.base    = b;
    q.push_back(r);
  endtask

  always @(negedge clk) begin : model_chk
    rec_t e;
    bit   rel;
    if (rst) begin
      q.delete();
      exp_rd  = '0;
      exp_rdn = 0;
      exp_wrn = 0;
    end
    if (!rst && q.size() != 0) begin
      e = q.pop_front();
    end else begin
      e      = '{default: 0};
      e.rdy  = !(rd_en || wr_en);
      e.we_n = 1;
      if (!rst && (rd_en || wr_en)) push_sched(wr_en, address, write_data);
    end
    if (e.last_rd) begin
      for (int k = 0; k < 4; k++)
        exp_rd[16*k +: 16] = mem[6'(e.base + 18'(k))];
      exp_rdn++;
    end
    if (e.last_wr) exp_wrn++;
    chk("ready", ready, e.rdy);
    chk("sram_addr", SRAM_ADDR, e.addr);
    chk("we_n", SRAM_WE_N, e.we_n);
    chk("oe_n", SRAM_OE_N, e.oe_n);
    if (e.drv) chk("dq_write", SRAM_DQ, e.dq);
    else if (mdl_on && !e.oe_n) chk("dq_read", SRAM_DQ, mem[e.addr[5:0]]);
    else begin
      rel = (SRAM_DQ === 16'hzzzz) || (SRAM_DQ === 16'h0000);
      chk("dq_released", rel, 1);
    end
    if (!e.acc) chk("read_data", read_data, exp_rd);
`ifdef SRAM_STATS_EN
    chk("stat_rd_cnt", stat_rd_cnt, exp_rdn);
    chk("stat_wr_cnt", stat_wr_cnt, exp_wrn);
`endif
  end

  logic [17:0] tr_addr [0:63];
  logic [17:0] we_addr [0:7];
  logic [15:0] we_dq   [0:7];
  int          we_low;
  bit          oe_hi;

  // Called at posedge+1; returns cycles from the request cycle (0) to ready
  task automatic run_req(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                         input bit hold, output int cyc);
    wr_en = w; rd_en = r; address = a; write_data = d;
    we_low = 0; oe_hi = 0; cyc = 0;
    while (cyc <= 40) begin
      @(negedge clk);
      if (cyc < 64) tr_addr[cyc] = SRAM_ADDR;
      if (!SRAM_WE_N) begin
        if (we_low < 8) begin we_addr[we_low] = SRAM_ADDR; we_dq[we_low] = SRAM_DQ; end
        we_low++;
      end
      if (SRAM_OE_N) oe_hi = 1;
      if (ready) break;
      cyc++;
    end
    @(posedge clk); #1;
    if (!hold) begin wr_en = 0; rd_en = 0; end
  endtask

  initial begin
    int cyc;
    rst = 1; rd_en = 0; wr_en = 0; address = 0; write_data = 0; mdl_on = 0;
    for (int k = 0; k < 64; k++) mem[k] = 16'h5A00 + 16'(k);
    mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'h0003; mem[3] = 16'h0004;
    mem[4] = 16'h0011; mem[5] = 16'h0022; mem[6] = 16'h0033; mem[7] = 16'h0044;
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", ready, 1);
    chk("rst_we_n", SRAM_WE_N, 1);
    chk("rst_oe_n", SRAM_OE_N, 0);
    chk("rst_addr", SRAM_ADDR, 0);
    chk("rst_read_data", read_data, 64'h0);
    rst = 0;
    repeat (3) @(posedge clk); #1;
    mdl_on = 1;

    run_req(1, 0, 32'd1028, 32'hDEADBEEF, 0, cyc);
    chk("wr_latency", cyc, 5);
    chk("wr_we_pulses", we_low, 2);
    chk("wr_addr0", we_addr[0], 18'd2);
    chk("wr_dq0", we_dq[0], 16'hBEEF);
    chk("wr_addr1", we_addr[1], 18'd3);
    chk("wr_dq1", we_dq[1], 16'hDEAD);
    chk("wr_read_data_kept", read_data, 64'h0);

    run_req(0, 1, 32'd1030, 32'h0, 0, cyc);
    chk("rd_latency", cyc, 9);
    chk("rd_addr_hw0", tr_addr[1], 18'd0);
    chk("rd_addr_hw1", tr_addr[3], 18'd1);
    chk("rd_addr_hw2", tr_addr[5], 18'd2);
    chk("rd_addr_hw3", tr_addr[7], 18'd3);
    chk("rd_no_we", we_low, 0);
    chk("rd_line", read_data, 64'h0004_0003_0002_0001);

    run_req(1, 1, 32'd1040, 32'h12345678, 0, cyc);
    chk("both_latency", cyc, 5);
    chk("both_we_pulses", we_low, 2);
    chk("both_oe_high", oe_hi, 1);
    chk("both_read_data_kept", read_data, 64'h0004_0003_0002_0001);

    rd_en = 1; address = 32'd1030;
    repeat (3) @(posedge clk);
    #2;
    rst = 1; rd_en = 0;
    #1;
    chk("midrst_addr", SRAM_ADDR, 0);
    chk("midrst_we_n", SRAM_WE_N, 1);
    chk("midrst_oe_n", SRAM_OE_N, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_read_data", read_data, 64'h0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    run_req(0, 1, 32'd1032, 32'h0, 0, cyc);
    chk("postrst_latency", cyc, 9);
    chk("postrst_line", read_data, 64'h0044_0033_0022_0011);

    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    run_req(0, 1, 32'd1024, 32'h0, 1, cyc);
    chk("b2b_rd1_latency", cyc, 9);
    chk("b2b_rd1_line", read_data, 64'h0004_0003_0002_0001);
    run_req(1, 0, 32'd1036, 32'hCAFE0123, 1, cyc);
    chk("b2b_wr_latency", cyc, 5);
    chk("b2b_wr_addr0", we_addr[0], 18'd6);
    chk("b2b_wr_dq1", we_dq[1], 16'hCAFE);
    run_req(0, 1, 32'd1032, 32'h0, 0, cyc);
    chk("b2b_rd2_latency", cyc, 9);
    chk("b2b_rd2_line", read_data, 64'h0044_0033_0022_0011);
`ifdef SRAM_STATS_EN
    chk("stat_rd_total", stat_rd_cnt, 32'd2);
    chk("stat_wr_total", stat_wr_cnt, 32'd1);
`endif
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
